mc_controller: RTL and testbench

- Main sequencer for the multicycle RV32I core. Shares one ALU, one memory port and one instruction register across the fetch, decode, execute, memory and writeback steps.
- Moore FSM on the instruction opcode, with an embedded ALU-control decoder.
- Drives every mux select and write enable of the multicycle datapath.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

---
 rtl/mc_pkg.sv | 53 +++++
 rtl/mc_controller_aludec.sv | 33 +++
 rtl/mc_controller.sv | 158 +++++++++++++++
 tb/tb_mc_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states,
// opcodes and datapath mux/ALU codes.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALUC_ADD = 3'b000;
   localparam logic [2:0] ALUC_SUB = 3'b001;
   localparam logic [2:0] ALUC_AND = 3'b010;
   localparam logic [2:0] ALUC_OR  = 3'b011;
   localparam logic [2:0] ALUC_SLT = 3'b101;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU-control decoder: maps ALUOp plus funct fields to an ALU operation.
module aludec
   import mc_pkg::*;
#(
   parameter logic [2:0] DEFAULT_CTRL = 3'b000
) (
   input  logic       opb5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic [1:0] ALUOp,
   output logic [2:0] ALUControl
);

   always_comb begin
      ALUControl = ALUC_ADD;
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALUC_ADD;
         ALUOP_SUB: ALUControl = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7b5 only means sub for R-type; addi reuses that bit as immediate
               3'b000:  ALUControl = (funct7b5 & opb5) ? ALUC_SUB : ALUC_ADD;
               3'b010:  ALUControl = ALUC_SLT;
               3'b110:  ALUControl = ALUC_OR;
               3'b111:  ALUControl = ALUC_AND;
               default: ALUControl = DEFAULT_CTRL;
            endcase
         end
         default: ALUControl = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Main sequencer for the multicycle RV32I core: Moore FSM on the opcode
// driving every datapath select and write enable.
module mc_controller
   import mc_pkg::*;
#(
   parameter int unsigned STATE_W = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic [2:0] ALUControl,
   output logic       instr_done,
   output logic       illegal_op
);

   logic [STATE_W-1:0] state_q;
   state_t             state_d;
   state_t             state_cur;
   logic               pc_update, branch, mem_wr, ir_wr, reg_wr, done, illegal;
   logic [1:0]         alu_op;

   assign state_cur = state_t'(state_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = S_FETCH;
      pc_update = 1'b0;
      branch    = 1'b0;
      mem_wr    = 1'b0;
      ir_wr     = 1'b0;
      reg_wr    = 1'b0;
      done      = 1'b0;
      illegal   = 1'b0;
      alu_op    = ALUOP_ADD;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RD2;
      case (state_cur)
         S_FETCH: begin
            state_d   = S_DECODE;
            ir_wr     = 1'b1;
            pc_update = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            state_d = S_MEMWB;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            reg_wr    = 1'b1;
            done      = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_wr = 1'b1;
            done   = 1'b1;
         end
         S_EXECR: begin
            state_d = S_ALUWB;
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            alu_op  = ALUOP_FUNCT;
         end
         S_EXECI: begin
            state_d = S_ALUWB;
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_wr = 1'b1;
            done   = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
            done    = 1'b1;
         end
         S_JAL: begin
            state_d   = S_ALUWB;
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      case (op)
         OP_LW, OP_I: ImmSrc = IMM_I;
         OP_SW:       ImmSrc = IMM_S;
         OP_BEQ:      ImmSrc = IMM_B;
         OP_JAL:      ImmSrc = IMM_J;
         default:     ImmSrc = IMM_I;
      endcase
   end

   // Enables are gated by reset_n so they drop in the cycle reset is asserted
   assign PCWrite    = reset_n & (pc_update | (branch & Zero));
   assign IRWrite    = reset_n & ir_wr;
   assign MemWrite   = reset_n & mem_wr;
   assign RegWrite   = reset_n & reg_wr;
   assign instr_done = reset_n & done;
   assign illegal_op = reset_n & illegal;

   aludec #(
      .DEFAULT_CTRL(ALUC_ADD)
   ) u_aludec (
      .opb5      (op[5]),
      .funct3    (funct3),
      .funct7b5  (funct7b5),
      .ALUOp     (alu_op),
      .ALUControl(ALUControl)
   );

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the driver queues hand-derived per-cycle
// output vectors, the monitor compares them on the falling edge.
module tb_mc_controller;

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic [1:0] rsrc;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [1:0] imm;
      logic       regw;
      logic [2:0] aluc;
      logic       done;
      logic       ill;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    failures = 0;
   exp_t  act;

   always #5 clk = ~clk;

   mc_controller #(.STATE_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
      .instr_done(instr_done), .illegal_op(illegal_op)
   );

   assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ImmSrc, RegWrite, ALUControl, instr_done, illegal_op};

   // Hand-coded per-state output table
   function automatic exp_t st_exp(input int s, input logic [1:0] imm, input logic [2:0] xalu,
                                   input logic zero, input logic ill);
      exp_t e;
      e = '0;
      e.imm = imm;
      case (s)
         0:  begin e.pcw = 1'b1; e.irw = 1'b1; e.srcb = 2'b10; e.rsrc = 2'b10; end
         1:  begin e.srca = 2'b01; e.srcb = 2'b01; e.ill = ill; end
         2:  begin e.srca = 2'b10; e.srcb = 2'b01; end
         3:  begin e.adr = 1'b1; end
         4:  begin e.rsrc = 2'b01; e.regw = 1'b1; e.done = 1'b1; end
         5:  begin e.adr = 1'b1; e.memw = 1'b1; e.done = 1'b1; end
         6:  begin e.srca = 2'b10; e.srcb = 2'b00; e.aluc = xalu; end
         7:  begin e.srca = 2'b10; e.srcb = 2'b01; e.aluc = xalu; end
         8:  begin e.regw = 1'b1; e.done = 1'b1; end
         9:  begin e.srca = 2'b10; e.aluc = 3'b001; e.pcw = zero; e.done = 1'b1; end
         10: begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic exp_t reset_exp(input logic [1:0] imm);
      exp_t e;
      e = st_exp(0, imm, 3'b000, 1'b0, 1'b0);
      e.pcw = 1'b0;
      e.irw = 1'b0;
      return e;
   endfunction

   task automatic push(input exp_t e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // seq holds up to five 4-bit states, first state in the top nibble
   task automatic run(input string nm, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z, input logic [1:0] imm,
                      input logic [2:0] xalu, input logic ill,
                      input logic [19:0] seq, input int n);
      logic [3:0] s;
      op = o; funct3 = f3; funct7b5 = f7; Zero = z;
      for (int i = 0; i < n; i++) begin
         s = seq[19-4*i -: 4];
         push(st_exp(int'(s), imm, xalu, z, ill), $sformatf("%s_c%0d", nm, i + 1));
         @(posedge clk); #2;
      end
   endtask

   initial begin : monitor
      exp_t  e;
      string t;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e)
               begin
                  failures++;
                  $display("FAIL %s: got=%h expected=%h", t, act, e);
               end
         end
      end
   end

   initial begin : driver
      @(posedge clk); #2;
      push(reset_exp(2'b00), "reset_a"); @(posedge clk); #2;
      push(reset_exp(2'b00), "reset_b"); @(posedge clk); #2;
      reset_n = 1'b1;

      run("lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, {4'd0,4'd1,4'd2,4'd3,4'd4}, 5);
      run("sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, {4'd0,4'd1,4'd2,4'd5,4'd0}, 4);
      run("sub",   7'b0110011, 3'b000, 1'b1, 1'b1, 2'b00, 3'b001, 1'b0, {4'd0,4'd1,4'd6,4'd8,4'd0}, 4);
      run("and",   7'b0110011, 3'b111, 1'b0, 1'b0, 2'b00, 3'b010, 1'b0, {4'd0,4'd1,4'd6,4'd8,4'd0}, 4);
      run("addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, {4'd0,4'd1,4'd7,4'd8,4'd0}, 4);
      run("slti",  7'b0010011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b101, 1'b0, {4'd0,4'd1,4'd7,4'd8,4'd0}, 4);
      run("ori",   7'b0010011, 3'b110, 1'b0, 1'b0, 2'b00, 3'b011, 1'b0, {4'd0,4'd1,4'd7,4'd8,4'd0}, 4);
      run("xor_r", 7'b0110011, 3'b100, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, {4'd0,4'd1,4'd6,4'd8,4'd0}, 4);
      run("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0, {4'd0,4'd1,4'd9,4'd0,4'd0}, 3);
      run("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10, 3'b000, 1'b0, {4'd0,4'd1,4'd9,4'd0,4'd0}, 3);
      run("illeg", 7'b1111111, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, {4'd0,4'd1,4'd0,4'd0,4'd0}, 2);
      run("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 2'b11, 3'b000, 1'b0, {4'd0,4'd1,4'd10,4'd8,4'd0}, 4);

      // Reset asserted during EXECR of an add: ALUWB must never happen
      op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
      push(st_exp(0, 2'b00, 3'b000, 1'b0, 1'b0), "rst_fetch"); @(posedge clk); #2;
      push(st_exp(1, 2'b00, 3'b000, 1'b0, 1'b0), "rst_decode"); @(posedge clk); #2;
      push(st_exp(6, 2'b00, 3'b000, 1'b0, 1'b0), "rst_execr");
      @(negedge clk); #1;
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         push(reset_exp(2'b00), $sformatf("rst_hold%0d", i + 1));
      end
      @(posedge clk); #2;
      reset_n = 1'b1;
      run("post_rst", 7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, {4'd0,4'd1,4'd6,4'd8,4'd0}, 4);

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
